thirty_two_bits_full_adder: RTL and testbench



---
 rtl/thirty_two_bits_full_adder.sv | 62 ++++++
 tb/tb_thirty_two_bits_full_adder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/thirty_two_bits_full_adder.sv
// Registered 32-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// This is the integer add datapath of the ALU, built from one full-adder cell per bit.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic p;

  assign p   = a ^ b;
  assign sum = p ^ ci;
  assign co  = (a & b) | (ci & p);

endmodule

module thirty_two_bits_full_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = c0;

  // One cell per bit; carry[i] feeds cell i, carry[WIDTH] is the final carry out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .ci  (carry[i]),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      s    <= sum;
      cout <= carry[WIDTH];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_thirty_two_bits_full_adder.sv
// Scoreboard bench for thirty_two_bits_full_adder: directed vectors with hand-computed
// expectations are queued at drive time and checked by an independent monitor.

module tb_thirty_two_bits_full_adder;

  typedef struct {
    string       name;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } expect_t;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        c0;
  logic [31:0] s;
  logic        cout;
  logic        ovf;

  expect_t sb[$];
  int      vectors_applied;
  int      miscompares;

  thirty_two_bits_full_adder dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c0   (c0),
    .s    (s),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector per cycle on the falling edge and queue what the next rising edge must produce.
  task automatic apply_stimulus(input string name, input logic r, input logic [31:0] va,
                                input logic [31:0] vb, input logic vc,
                                input logic [31:0] es, input logic ec, input logic eo);
    expect_t e;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    c0  = vc;
    e.name = name;
    e.s    = es;
    e.cout = ec;
    e.ovf  = eo;
    sb.push_back(e);
  endtask

  task automatic check_output(input expect_t e);
    vectors_applied++;
    if (s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
               e.name, s, cout, ovf, e.s, e.cout, e.ovf);
    end
  endtask

  // Monitor: the DUT presents a result every cycle, so pop one expectation per rising edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    c0  = 1'b0;

    apply_stimulus("reset0", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("reset1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b0);
    apply_stimulus("first_after_reset", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);

    apply_stimulus("ripple_ff_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    apply_stimulus("ripple_ff_faff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFAFF, 1'b1, 32'hFFFFFAFF, 1'b1, 1'b0);
    apply_stimulus("ripple_ff_0_c1", 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);

    apply_stimulus("dec0", 1'b0, 32'd1092657, 32'd1534, 1'b0, 32'd1094191, 1'b0, 1'b0);
    apply_stimulus("dec1", 1'b0, 32'd2526234, 32'd1274323, 1'b0, 32'd3800557, 1'b0, 1'b0);
    apply_stimulus("dec2", 1'b0, 32'd90221, 32'd8821000, 1'b0, 32'd8911221, 1'b0, 1'b0);
    apply_stimulus("dec3", 1'b0, 32'd345678, 32'd987654, 1'b0, 32'd1333332, 1'b0, 1'b0);

    apply_stimulus("small_12_10", 1'b0, 32'd12, 32'd10, 1'b0, 32'd22, 1'b0, 1'b0);
    apply_stimulus("small_15_15", 1'b0, 32'd15, 32'd15, 1'b0, 32'd30, 1'b0, 1'b0);
    apply_stimulus("small_15_15_c1", 1'b0, 32'd15, 32'd15, 1'b1, 32'd31, 1'b0, 1'b0);
    apply_stimulus("small_3_4", 1'b0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);
    apply_stimulus("small_9_9", 1'b0, 32'd9, 32'd9, 1'b0, 32'd18, 1'b0, 1'b0);
    apply_stimulus("small_5_1", 1'b0, 32'd5, 32'd1, 1'b0, 32'd6, 1'b0, 1'b0);

    apply_stimulus("ovf_pos", 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    apply_stimulus("ovf_neg", 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset lands on the third vector of the stream, which is then re-issued.
    apply_stimulus("mid_dec0", 1'b0, 32'd1092657, 32'd1534, 1'b0, 32'd1094191, 1'b0, 1'b0);
    apply_stimulus("mid_dec1", 1'b0, 32'd2526234, 32'd1274323, 1'b0, 32'd3800557, 1'b0, 1'b0);
    apply_stimulus("mid_reset", 1'b1, 32'd90221, 32'd8821000, 1'b0, 32'h0, 1'b0, 1'b0);
    apply_stimulus("mid_dec2", 1'b0, 32'd90221, 32'd8821000, 1'b0, 32'd8911221, 1'b0, 1'b0);
    apply_stimulus("mid_dec3", 1'b0, 32'd345678, 32'd987654, 1'b0, 32'd1333332, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left in scoreboard, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
